// File: rtl/spu_pkg.sv
// Shared widths, pipe ids, issue-state encoding and slot/output records
// for the SPU dual-issue stage.
package spu_pkg;

  localparam int unsigned NUM_REGS = 128;
  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned ID_W     = 7;
  localparam int unsigned REG_W    = 7;
  localparam int unsigned UNIT_W   = 3;
  localparam int unsigned LAT_W    = 4;

  localparam logic PIPE_EVEN = 1'b0;
  localparam logic PIPE_ODD  = 1'b1;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_AB    = 2'd1,
    S_B     = 2'd2
  } issue_state_e;

  // One decoded instruction as held in an issue slot; src/use_src index 0..2 = ra, rb, rc
  typedef struct packed {
    logic [INSTR_W-1:0]    instr;
    logic [ID_W-1:0]       id;
    logic                  pipe;
    logic [UNIT_W-1:0]     unit_id;
    logic [LAT_W-1:0]      latency;
    logic                  reg_wr;
    logic [REG_W-1:0]      reg_dst;
    logic [2:0][REG_W-1:0] src;
    logic [2:0]            use_src;
  } slot_t;

  // Fields driven to one pipe of the RF/FU wrapper, in output port order
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ID_W-1:0]    id;
    logic [REG_W-1:0]   reg_dst;
    logic [UNIT_W-1:0]  unit_id;
    logic [LAT_W-1:0]   latency;
    logic               reg_wr;
    logic [REG_W-1:0]   ra;
    logic [REG_W-1:0]   rb;
    logic [REG_W-1:0]   rc;
  } pipe_out_t;

  localparam pipe_out_t NOP_OUT = '0;

endpackage

// File: rtl/spu_issue_scoreboard.sv
// Per-register result-latency countdown with 8 combinational read ports
// and 2 load ports (slot A = port 0, slot B = port 1).
module spu_issue_scoreboard #(
  parameter  int unsigned NUM_REGS = 128,
  parameter  int unsigned LAT_W    = 4,
  localparam int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0][IDX_W-1:0] rd_addr,
  output logic [7:0][LAT_W-1:0] rd_score,
  input  logic [1:0]            ld_en,
  input  logic [1:0][IDX_W-1:0] ld_addr,
  input  logic [1:0][LAT_W-1:0] ld_val
);

  logic [LAT_W-1:0] score [NUM_REGS];

  // Combinational read of the current counts
  always_comb begin
    rd_score = '0;
    for (int unsigned p = 0; p < 8; p++) rd_score[p] = score[rd_addr[p]];
  end

  // Load on issue beats the per-cycle decrement of every busy count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) score[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (ld_en[1] && ld_addr[1] == IDX_W'(i))      score[i] <= ld_val[1];
        else if (ld_en[0] && ld_addr[0] == IDX_W'(i)) score[i] <= ld_val[0];
        else if (score[i] != '0)                      score[i] <= score[i] - LAT_W'(1);
      end
    end
  end

endmodule

// File: rtl/spu_dual_issue_stage.sv
// In-order dual-issue stage: holds one decoded pair, resolves structural,
// RAW and WAW hazards against the scoreboard and drives registered
// even/odd pipe fields to the RF/FU wrapper.
module spu_dual_issue_stage
  import spu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               dec_valid,
  output logic               dec_ready,
  input  logic [INSTR_W-1:0] a_instr,
  input  logic [ID_W-1:0]    a_instr_id,
  input  logic               a_pipe,
  input  logic [UNIT_W-1:0]  a_unit_id,
  input  logic [LAT_W-1:0]   a_latency,
  input  logic               a_reg_wr,
  input  logic [REG_W-1:0]   a_reg_dst,
  input  logic [REG_W-1:0]   a_ra,
  input  logic [REG_W-1:0]   a_rb,
  input  logic [REG_W-1:0]   a_rc,
  input  logic               a_use_ra,
  input  logic               a_use_rb,
  input  logic               a_use_rc,
  input  logic [INSTR_W-1:0] b_instr,
  input  logic [ID_W-1:0]    b_instr_id,
  input  logic               b_pipe,
  input  logic [UNIT_W-1:0]  b_unit_id,
  input  logic [LAT_W-1:0]   b_latency,
  input  logic               b_reg_wr,
  input  logic [REG_W-1:0]   b_reg_dst,
  input  logic [REG_W-1:0]   b_ra,
  input  logic [REG_W-1:0]   b_rb,
  input  logic [REG_W-1:0]   b_rc,
  input  logic               b_use_ra,
  input  logic               b_use_rb,
  input  logic               b_use_rc,
  output logic [INSTR_W-1:0] full_instr_even,
  output logic [INSTR_W-1:0] full_instr_odd,
  output logic [ID_W-1:0]    instr_id_even,
  output logic [ID_W-1:0]    instr_id_odd,
  output logic [REG_W-1:0]   reg_dst_even,
  output logic [REG_W-1:0]   reg_dst_odd,
  output logic [UNIT_W-1:0]  unit_id_even,
  output logic [UNIT_W-1:0]  unit_id_odd,
  output logic [LAT_W-1:0]   latency_even,
  output logic [LAT_W-1:0]   latency_odd,
  output logic               reg_wr_even,
  output logic               reg_wr_odd,
  output logic [REG_W-1:0]   ra_addr_even,
  output logic [REG_W-1:0]   ra_addr_odd,
  output logic [REG_W-1:0]   rb_addr_even,
  output logic [REG_W-1:0]   rb_addr_odd,
  output logic [REG_W-1:0]   rc_addr_even,
  output logic [REG_W-1:0]   rc_addr_odd
);

  issue_state_e           state, state_nx;
  slot_t                  in_a, in_b, slot_a, slot_b;
  pipe_out_t              a_out, b_out, nx_even, nx_odd, out_even, out_odd;
  logic                   a_rdy, b_rdy, b_raw, pair_conflict, issue_a, issue_b, load;
  logic [7:0][REG_W-1:0]  sb_addr;
  logic [7:0][LAT_W-1:0]  sb_score;
  logic [1:0]             ld_en;
  logic [1:0][REG_W-1:0]  ld_addr;
  logic [1:0][LAT_W-1:0]  ld_val;

  assign in_a = '{instr: a_instr, id: a_instr_id, pipe: a_pipe, unit_id: a_unit_id,
                  latency: a_latency, reg_wr: a_reg_wr, reg_dst: a_reg_dst,
                  src: {a_rc, a_rb, a_ra}, use_src: {a_use_rc, a_use_rb, a_use_ra}};
  assign in_b = '{instr: b_instr, id: b_instr_id, pipe: b_pipe, unit_id: b_unit_id,
                  latency: b_latency, reg_wr: b_reg_wr, reg_dst: b_reg_dst,
                  src: {b_rc, b_rb, b_ra}, use_src: {b_use_rc, b_use_rb, b_use_ra}};

  assign a_out = '{instr: slot_a.instr, id: slot_a.id, reg_dst: slot_a.reg_dst,
                   unit_id: slot_a.unit_id, latency: slot_a.latency, reg_wr: slot_a.reg_wr,
                   ra: slot_a.src[0], rb: slot_a.src[1], rc: slot_a.src[2]};
  assign b_out = '{instr: slot_b.instr, id: slot_b.id, reg_dst: slot_b.reg_dst,
                   unit_id: slot_b.unit_id, latency: slot_b.latency, reg_wr: slot_b.reg_wr,
                   ra: slot_b.src[0], rb: slot_b.src[1], rc: slot_b.src[2]};

  // Scoreboard ports: 0-2 A sources, 3-5 B sources, 6/7 A/B destinations
  always_comb begin
    sb_addr = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      sb_addr[k]     = slot_a.src[k];
      sb_addr[k + 3] = slot_b.src[k];
    end
    sb_addr[6] = slot_a.reg_dst;
    sb_addr[7] = slot_b.reg_dst;
  end

  assign ld_en   = {issue_b && slot_b.reg_wr, issue_a && slot_a.reg_wr};
  assign ld_addr = {slot_b.reg_dst, slot_a.reg_dst};
  assign ld_val  = {slot_b.latency, slot_a.latency};

  spu_issue_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .LAT_W    (LAT_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (sb_addr),
    .rd_score (sb_score),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_val   (ld_val)
  );

  // Per-slot hazard readiness and intra-pair RAW/WAW conflict
  always_comb begin
    a_rdy = !(slot_a.reg_wr && sb_score[6] != '0);
    b_rdy = !(slot_b.reg_wr && sb_score[7] != '0);
    b_raw = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      if (slot_a.use_src[k] && sb_score[k] != '0)     a_rdy = 1'b0;
      if (slot_b.use_src[k] && sb_score[k + 3] != '0) b_rdy = 1'b0;
      if (slot_b.use_src[k] && slot_b.src[k] == slot_a.reg_dst) b_raw = 1'b1;
    end
    pair_conflict = slot_a.reg_wr &&
                    (b_raw || (slot_b.reg_wr && slot_b.reg_dst == slot_a.reg_dst));
  end

  // Issue decision, decode handshake and next state
  always_comb begin
    issue_a  = 1'b0;
    issue_b  = 1'b0;
    state_nx = state;
    case (state)
      S_AB: begin
        if (a_rdy && b_rdy && (slot_a.pipe != slot_b.pipe) && !pair_conflict) begin
          issue_a  = 1'b1;
          issue_b  = 1'b1;
          state_nx = S_EMPTY;
        end else if (a_rdy) begin
          issue_a  = 1'b1;
          state_nx = S_B;
        end
      end
      S_B: begin
        if (b_rdy) begin
          issue_b  = 1'b1;
          state_nx = S_EMPTY;
        end
      end
      default: ;
    endcase
    // Ready exactly when every held slot drains this cycle
    dec_ready = rst && !flush && (state_nx == S_EMPTY);
    load      = dec_valid && dec_ready;
    if (flush) begin
      issue_a  = 1'b0;
      issue_b  = 1'b0;
      state_nx = S_EMPTY;
    end else if (load) begin
      state_nx = S_AB;
    end
  end

  // Route issued slots to their pipes; an idle pipe gets a NOP
  always_comb begin
    nx_even = NOP_OUT;
    nx_odd  = NOP_OUT;
    if (issue_a) begin
      if (slot_a.pipe == PIPE_ODD) nx_odd = a_out;
      else                         nx_even = a_out;
    end
    if (issue_b) begin
      if (slot_b.pipe == PIPE_ODD) nx_odd = b_out;
      else                         nx_even = b_out;
    end
  end

  // State, slot and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_EMPTY;
      slot_a   <= '0;
      slot_b   <= '0;
      out_even <= NOP_OUT;
      out_odd  <= NOP_OUT;
    end else begin
      state    <= state_nx;
      out_even <= nx_even;
      out_odd  <= nx_odd;
      if (load) begin
        slot_a <= in_a;
        slot_b <= in_b;
      end
    end
  end

  assign {full_instr_even, instr_id_even, reg_dst_even, unit_id_even, latency_even,
          reg_wr_even, ra_addr_even, rb_addr_even, rc_addr_even} = out_even;
  assign {full_instr_odd, instr_id_odd, reg_dst_odd, unit_id_odd, latency_odd,
          reg_wr_odd, ra_addr_odd, rb_addr_odd, rc_addr_odd} = out_odd;

endmodule

// File: tb/tb_spu_dual_issue_stage.sv
// Bench for spu_dual_issue_stage: directed table, reset sequence and
// random pairs, all checked against a timestamp-based issue model.
module tb_spu_dual_issue_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [6:0]  id;
    logic        pipe;
    logic [2:0]  unit;
    logic [3:0]  lat;
    logic        wr;
    logic [6:0]  dst;
    logic [6:0]  ra;
    logic [6:0]  rb;
    logic [6:0]  rc;
    logic [2:0]  use_m;   // bit0 ra, bit1 rb, bit2 rc
  } ins_t;

  typedef struct {
    logic       dv;
    logic       fl;
    ins_t       a;
    ins_t       b;
    logic       er;
    logic [6:0] ide;
    logic [6:0] ido;
  } row_t;

  logic clk = 1'b0;
  logic rst, flush, dec_valid, dec_ready;
  ins_t va, vb;
  logic [31:0] full_instr_even, full_instr_odd;
  logic [6:0]  instr_id_even, instr_id_odd, reg_dst_even, reg_dst_odd;
  logic [2:0]  unit_id_even, unit_id_odd;
  logic [3:0]  latency_even, latency_odd;
  logic        reg_wr_even, reg_wr_odd;
  logic [6:0]  ra_addr_even, ra_addr_odd, rb_addr_even, rb_addr_odd, rc_addr_even, rc_addr_odd;
  logic [74:0] dut_e, dut_o;

  always #5 clk = ~clk;

  spu_dual_issue_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .a_instr(va.instr), .a_instr_id(va.id), .a_pipe(va.pipe), .a_unit_id(va.unit),
    .a_latency(va.lat), .a_reg_wr(va.wr), .a_reg_dst(va.dst),
    .a_ra(va.ra), .a_rb(va.rb), .a_rc(va.rc),
    .a_use_ra(va.use_m[0]), .a_use_rb(va.use_m[1]), .a_use_rc(va.use_m[2]),
    .b_instr(vb.instr), .b_instr_id(vb.id), .b_pipe(vb.pipe), .b_unit_id(vb.unit),
    .b_latency(vb.lat), .b_reg_wr(vb.wr), .b_reg_dst(vb.dst),
    .b_ra(vb.ra), .b_rb(vb.rb), .b_rc(vb.rc),
    .b_use_ra(vb.use_m[0]), .b_use_rb(vb.use_m[1]), .b_use_rc(vb.use_m[2]),
    .full_instr_even(full_instr_even), .full_instr_odd(full_instr_odd),
    .instr_id_even(instr_id_even), .instr_id_odd(instr_id_odd),
    .reg_dst_even(reg_dst_even), .reg_dst_odd(reg_dst_odd),
    .unit_id_even(unit_id_even), .unit_id_odd(unit_id_odd),
    .latency_even(latency_even), .latency_odd(latency_odd),
    .reg_wr_even(reg_wr_even), .reg_wr_odd(reg_wr_odd),
    .ra_addr_even(ra_addr_even), .ra_addr_odd(ra_addr_odd),
    .rb_addr_even(rb_addr_even), .rb_addr_odd(rb_addr_odd),
    .rc_addr_even(rc_addr_even), .rc_addr_odd(rc_addr_odd)
  );

  assign dut_e = {full_instr_even, instr_id_even, reg_dst_even, unit_id_even, latency_even,
                  reg_wr_even, ra_addr_even, rb_addr_even, rc_addr_even};
  assign dut_o = {full_instr_odd, instr_id_odd, reg_dst_odd, unit_id_odd, latency_odd,
                  reg_wr_odd, ra_addr_odd, rb_addr_odd, rc_addr_odd};

  // Reference model: held pair as a queue, register busy as "busy through cycle N"
  ins_t        pend[$];
  ins_t        iss[$];
  int          busy[128];
  int          cyc;
  logic        m_ready, s_ready;
  logic [74:0] exp_e, exp_o;
  int          n_vec, n_bad;
  row_t        tbl[$];

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", nm, cyc, act, expv);
    end
  endtask

  function automatic logic [74:0] fields(ins_t s);
    return {s.instr, s.id, s.dst, s.unit, s.lat, s.wr, s.ra, s.rb, s.rc};
  endfunction

  function automatic bit rdy(ins_t s);
    if (s.use_m[0] && busy[s.ra] >= cyc) return 1'b0;
    if (s.use_m[1] && busy[s.rb] >= cyc) return 1'b0;
    if (s.use_m[2] && busy[s.rc] >= cyc) return 1'b0;
    if (s.wr && busy[s.dst] >= cyc) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit clash(ins_t a, ins_t b);
    if (!a.wr) return 1'b0;
    if (b.wr && b.dst == a.dst) return 1'b1;
    if ((b.use_m[0] && b.ra == a.dst) || (b.use_m[1] && b.rb == a.dst) ||
        (b.use_m[2] && b.rc == a.dst)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_eval();
    iss.delete();
    exp_e = '0;
    exp_o = '0;
    m_ready = 1'b0;
    if (!flush) begin
      if (pend.size() == 2) begin
        if (rdy(pend[0]) && rdy(pend[1]) && pend[0].pipe != pend[1].pipe && !clash(pend[0], pend[1])) begin
          iss.push_back(pend[0]);
          iss.push_back(pend[1]);
        end else if (rdy(pend[0])) begin
          iss.push_back(pend[0]);
        end
      end else if (pend.size() == 1 && rdy(pend[0])) begin
        iss.push_back(pend[0]);
      end
      m_ready = (iss.size() == pend.size());
    end
    foreach (iss[i]) begin
      if (iss[i].pipe) exp_o = fields(iss[i]);
      else             exp_e = fields(iss[i]);
    end
  endtask

  task automatic model_commit();
    foreach (iss[i]) if (iss[i].wr) busy[iss[i].dst] = cyc + int'(iss[i].lat);
    if (flush) pend.delete();
    else repeat (iss.size()) void'(pend.pop_front());
    if (!flush && m_ready && dec_valid) begin
      pend.delete();
      pend.push_back(va);
      pend.push_back(vb);
    end
    cyc++;
  endtask

  task automatic model_reset();
    pend.delete();
    iss.delete();
    foreach (busy[i]) busy[i] = -1;
  endtask

  // One clock: check handshake mid-cycle, then registered outputs after the edge
  task automatic step();
    @(negedge clk);
    model_eval();
    s_ready = dec_ready;
    chk("dec_ready", 96'(dec_ready), 96'(m_ready));
    @(posedge clk);
    model_commit();
    #1;
    chk("even_fields", 96'(dut_e), 96'(exp_e));
    chk("odd_fields", 96'(dut_o), 96'(exp_o));
  endtask

  task automatic reset_check(input string tag);
    rst = 1'b0;
    #1;
    chk({tag, "_even_zero"}, 96'(dut_e), 96'(0));
    chk({tag, "_odd_zero"}, 96'(dut_o), 96'(0));
    chk({tag, "_ready_low"}, 96'(dec_ready), 96'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic ins_t mk(int id, bit pipe, int lat, bit wr, int dst,
                              int ra, int rb, int rc, logic [2:0] um);
    ins_t s;
    s.instr = 32'hC0DE_0000 | (32'(id) * 32'h0101);
    s.id    = 7'(id);
    s.pipe  = pipe;
    s.unit  = 3'(id);
    s.lat   = 4'(lat);
    s.wr    = wr;
    s.dst   = 7'(dst);
    s.ra    = 7'(ra);
    s.rb    = 7'(rb);
    s.rc    = 7'(rc);
    s.use_m = um;
    return s;
  endfunction

  function automatic logic [6:0] rreg();
    return 7'($urandom_range(0, 5)) - 7'd2;   // 126, 127, 0..3
  endfunction

  function automatic ins_t rnd_ins();
    ins_t s;
    s.instr = $urandom;
    s.id    = 7'($urandom);
    s.pipe  = 1'($urandom_range(0, 1));
    s.unit  = 3'($urandom);
    s.lat   = 4'($urandom_range(0, 6));
    s.wr    = ($urandom_range(0, 3) != 0);
    s.dst   = rreg();
    s.ra    = rreg();
    s.rb    = rreg();
    s.rc    = rreg();
    s.use_m = 3'($urandom);
    return s;
  endfunction

  task automatic add(input logic dv, input logic fl, input ins_t a, input ins_t b,
                     input logic er, input int ide, input int ido);
    row_t r;
    r.dv = dv; r.fl = fl; r.a = a; r.b = b; r.er = er;
    r.ide = 7'(ide); r.ido = 7'(ido);
    tbl.push_back(r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t z, p13, p14;
    n_vec = 0; n_bad = 0; cyc = 0;
    z = '0; va = '0; vb = '0; flush = 1'b0; dec_valid = 1'b0;
    model_reset();

    // Directed table; row index equals model cycle
    add(1, 0, mk(1, 0, 2, 1, 3, 1, 2, 0, 3'b011), mk(2, 1, 6, 1, 5, 6, 0, 0, 3'b001), 1, 0, 0);
    add(1, 0, mk(3, 0, 1, 1, 10, 20, 0, 0, 3'b001), mk(4, 0, 1, 1, 11, 21, 0, 0, 3'b001), 1, 1, 2);
    add(1, 0, mk(5, 1, 3, 1, 4, 1, 0, 0, 3'b001), mk(6, 0, 1, 1, 12, 0, 4, 0, 3'b010), 0, 3, 0);
    add(1, 0, mk(5, 1, 3, 1, 4, 1, 0, 0, 3'b001), mk(6, 0, 1, 1, 12, 0, 4, 0, 3'b010), 1, 4, 0);
    add(0, 0, z, z, 0, 0, 5);
    repeat (3) add(0, 0, z, z, 0, 0, 0);
    add(0, 0, z, z, 1, 6, 0);
    add(0, 0, z, z, 1, 0, 0);
    add(1, 0, mk(7, 0, 6, 1, 9, 0, 0, 0, 3'b000), mk(8, 1, 0, 1, 13, 0, 0, 0, 3'b000), 1, 0, 0);
    add(0, 0, z, z, 1, 7, 8);
    add(0, 0, z, z, 1, 0, 0);
    add(1, 0, mk(9, 1, 2, 1, 9, 0, 0, 0, 3'b000), mk(10, 0, 1, 1, 14, 0, 0, 0, 3'b000), 1, 0, 0);
    repeat (4) add(0, 0, z, z, 0, 0, 0);
    add(0, 0, z, z, 1, 10, 9);
    add(0, 0, z, z, 1, 0, 0);
    add(1, 0, mk(11, 0, 5, 1, 15, 0, 0, 0, 3'b000), mk(12, 1, 1, 1, 16, 15, 0, 0, 3'b001), 1, 0, 0);
    add(0, 0, z, z, 0, 11, 0);
    add(0, 0, z, z, 0, 0, 0);
    p13 = mk(13, 0, 1, 1, 17, 0, 0, 15, 3'b100);
    p14 = mk(14, 1, 1, 1, 18, 0, 0, 0, 3'b000);
    add(1, 1, p13, p14, 0, 0, 0);
    add(1, 0, p13, p14, 1, 0, 0);
    repeat (2) add(0, 0, z, z, 0, 0, 0);
    add(0, 0, z, z, 1, 13, 14);
    add(0, 0, z, z, 1, 0, 0);

    reset_check("por");

    foreach (tbl[i]) begin
      dec_valid = tbl[i].dv;
      flush     = tbl[i].fl;
      va        = tbl[i].a;
      vb        = tbl[i].b;
      step();
      chk($sformatf("row%0d_ready", i), 96'(s_ready), 96'(tbl[i].er));
      chk($sformatf("row%0d_id_even", i), 96'(instr_id_even), 96'(tbl[i].ide));
      chk($sformatf("row%0d_id_odd", i), 96'(instr_id_odd), 96'(tbl[i].ido));
    end

    // Reset asserted while B is stalled behind a long-latency A
    dec_valid = 1'b1; flush = 1'b0;
    va = mk(20, 0, 9, 1, 20, 0, 0, 0, 3'b000);
    vb = mk(21, 1, 1, 1, 21, 20, 0, 0, 3'b001);
    step();
    dec_valid = 1'b0;
    step();
    chk("pre_reset_id_even", 96'(instr_id_even), 96'(20));
    #2;
    reset_check("mid_stall");
    dec_valid = 1'b1;
    va = mk(22, 0, 1, 1, 20, 20, 0, 0, 3'b001);
    vb = mk(23, 1, 1, 1, 21, 21, 0, 0, 3'b001);
    step();
    chk("post_reset_ready", 96'(s_ready), 96'(1));
    dec_valid = 1'b0;
    step();
    chk("post_reset_id_even", 96'(instr_id_even), 96'(22));
    chk("post_reset_id_odd", 96'(instr_id_odd), 96'(23));

    // Random pairs over a small register set to force hazards
    for (int n = 0; n < 500; n++) begin
      dec_valid = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      va        = rnd_ins();
      vb        = rnd_ins();
      step();
    end
    flush = 1'b0; dec_valid = 1'b0;
    repeat (12) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
